// File: rtl/dpram_port_arbiter.sv
// Two-requester arbiter for one synchronous dpram port: round-robin between
// fetch (r0) and load/store (r1), with a bounded read-modify-write lock for r1.
module dpram_port_arbiter #(
    parameter int unsigned N        = 16,
    parameter int unsigned DW       = 32,
    parameter int unsigned AW       = $clog2(N),
    parameter int unsigned LOCK_MAX = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          r0_req,
    input  logic          r0_we,
    input  logic [AW-1:0] r0_addr,
    input  logic [DW-1:0] r0_wdata,
    output logic          r0_gnt,
    output logic          r0_rvalid,
    output logic [DW-1:0] r0_rdata,
    input  logic          r1_req,
    input  logic          r1_we,
    input  logic          r1_lock,
    input  logic [AW-1:0] r1_addr,
    input  logic [DW-1:0] r1_wdata,
    output logic          r1_gnt,
    output logic          r1_rvalid,
    output logic [DW-1:0] r1_rdata,
    output logic          lock_abort,
    output logic          mem_en,
    output logic          mem_wen,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_din,
    input  logic [DW-1:0] mem_dout
);

    localparam int unsigned CW = (LOCK_MAX > 2) ? $clog2(LOCK_MAX) : 1;

    typedef enum logic {
        IDLE  = 1'b0,
        LOCK1 = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic          prio_q, prio_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          abort_q, abort_d;
    logic          rd_pend_q, rd_owner_q;
    logic          timeout;

    // State register, lock counter and read-response tracking
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            prio_q     <= 1'b0;
            cnt_q      <= '0;
            abort_q    <= 1'b0;
            rd_pend_q  <= 1'b0;
            rd_owner_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            prio_q     <= prio_d;
            cnt_q      <= cnt_d;
            abort_q    <= abort_d;
            rd_pend_q  <= (r0_gnt & ~r0_we) | (r1_gnt & ~r1_we);
            rd_owner_q <= r1_gnt;
        end
    end

    // Arbitration, lock entry/exit and priority update
    always_comb begin
        state_d = state_q;
        prio_d  = prio_q;
        cnt_d   = cnt_q;
        abort_d = 1'b0;
        r0_gnt  = 1'b0;
        r1_gnt  = 1'b0;
        timeout = (state_q == LOCK1) && (cnt_q == CW'(LOCK_MAX - 1));
        if (!rst) begin
            case (state_q)
                IDLE: begin
                    if (r0_req && r1_req) begin
                        r0_gnt = ~prio_q;
                        r1_gnt = prio_q;
                    end else begin
                        r0_gnt = r0_req;
                        r1_gnt = r1_req;
                    end
                    if (r0_gnt) begin
                        prio_d = 1'b1;
                    end else if (r1_gnt) begin
                        prio_d = 1'b0;
                    end
                    cnt_d = '0;
                    if (r1_gnt && r1_lock) begin
                        state_d = LOCK1;
                    end
                end
                LOCK1: begin
                    r1_gnt = r1_req;
                    cnt_d  = cnt_q + CW'(1);
                    if (timeout) begin
                        // Forced release; any r1 access granted now still completes
                        state_d = IDLE;
                        prio_d  = 1'b0;
                        abort_d = 1'b1;
                        cnt_d   = '0;
                    end else if ((r1_gnt && !r1_lock) || (!r1_req && !r1_lock)) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Memory port driven from whichever requester holds the grant
    always_comb begin
        mem_en   = r0_gnt | r1_gnt;
        mem_wen  = 1'b0;
        mem_addr = '0;
        mem_din  = '0;
        if (r0_gnt) begin
            mem_wen  = r0_we;
            mem_addr = r0_addr;
            mem_din  = r0_wdata;
        end else if (r1_gnt) begin
            mem_wen  = r1_we;
            mem_addr = r1_addr;
            mem_din  = r1_wdata;
        end
    end

    // Responses are suppressed while reset is held so a read granted just
    // before reset never reports valid data
    assign r0_rvalid  = rd_pend_q & ~rd_owner_q & ~rst;
    assign r1_rvalid  = rd_pend_q & rd_owner_q & ~rst;
    assign lock_abort = abort_q & ~rst;
    assign r0_rdata   = mem_dout;
    assign r1_rdata   = mem_dout;

endmodule
